imem_loader: RTL
================

# imem_loader

Boot-time writer for the core's instruction memory. It accepts a framed byte stream over a valid/ready handshake, packs bytes little-endian into 32-bit instruction words, and writes them to consecutive instruction-memory word addresses. It holds the processor in reset until a complete frame with a correct checksum has been written. It sits beside `top_riscv`, driving the instruction-memory write port and the core's hold input.

## Interface
- `ADDR_W`, 8: instruction-memory word-address width; capacity is 2^ADDR_W words.
- `SYNC_BYTE`, 8'hA5: frame start marker.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `in_valid`  in  1  `in_data` carries a byte.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `imem_we`  out  1  one-cycle write strobe.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `core_hold`  out  1  keeps the core in reset while 1.
- `done`  out  1  last frame loaded and checked OK; sticky until the next sync byte.
- `error`  out  1  last frame failed; sticky until the next sync byte.

## Operation
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (N = 16-bit word count), 4·N data bytes (byte 0 goes to wdata[7:0]), then CSUM.
- CSUM is the 8-bit wrap-around sum of the data bytes only.
- States:
  - IDLE: sync → LEN0; other bytes are discarded.
  - LEN0: capture LEN_LO → LEN1.
  - LEN1: capture LEN_HI.
    - N > 2^ADDR_W → ERR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: accumulate bytes. After every 4th byte, write the word. After the N-th word → CSUM.
  - CSUM: byte equals the running sum → DONE; otherwise → ERR.
  - DONE / ERR: a sync byte → LEN0; other bytes are discarded.
- Entering LEN0 from any state does the following:
  - clears `done`, `error`, the checksum, the byte and word counters, and the address;
  - sets `core_hold` to 1.
- Address starts at 0 and increments after each write. N = 2^ADDR_W fills memory exactly; the address wraps to 0 after the last write with no extra write.
- Words already written before an ERR remain in memory. `core_hold` stays 1 in ERR.
- `core_hold` is 0 only in DONE.

## Timing
- Reset values:
  - state IDLE;
  - `in_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0;
  - `core_hold` = 1, `done` = 0, `error` = 0.
- `in_ready` is registered. It rises on the first edge after reset deasserts and is then constantly 1. The loader never backpressures.
- Write latency: `imem_we` = 1 for exactly the cycle after the edge that accepts the 4th byte of a word. `imem_addr` and `imem_wdata` are valid in that same cycle.
- `done`, `error`, and the `core_hold` change are registered and appear the cycle after the CSUM byte (or the illegal LEN_HI byte) is accepted.
- Gaps are allowed: `in_valid` low for any number of cycles between bytes does not change state or counters.
- `imem_we` never pulses in IDLE, LEN0, LEN1, CSUM, DONE, or ERR.
- Reset asserted mid-frame forces all reset values immediately. A partial word is dropped and the next frame writes from address 0.

## Structure
- Shared package `loader_pkg`: state enum (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR), the default SYNC_BYTE constant, and the frame length width (16).
- One sub-module, `byte_packer`:
  - 2-bit byte index and 32-bit shift/assemble register;
  - emits `word_valid` on the 4th byte;
  - has a synchronous clear driven on LEN0 entry.
- The top contains the FSM, word counter, address counter, checksum accumulator, and output registers.

## Test plan
- Bytes A5 02 00 13 00 00 00 93 00 10 00 B6 → writes addr0 = 32'h00000013, then addr1 = 32'h00100093; then `done` = 1, `core_hold` = 0, `error` = 0.
- Same frame with CSUM = B7 → both writes occur; `error` = 1, `core_hold` = 1, `done` = 0.
- A5 00 00 00 → no `imem_we` pulse; `done` = 1, `core_hold` = 0.
- With ADDR_W = 8, send A5 01 01 (N = 257) → `error` = 1 one cycle after LEN_HI; no writes; a following valid frame loads normally.
- Random `in_valid` gaps plus junk bytes 00 FF 12 in IDLE before the scenario-1 frame → identical writes and `done` = 1.
- Reset pulled low after 6 data bytes of scenario 1 → all outputs take reset values and `in_ready` returns 1 on the first edge after release; a full retransmission then writes addr0 (not addr1) first.

Source files
------------

// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared definitions for the instruction-memory boot loader.
//   state_e            : loader FSM states
//   DEFAULT_SYNC_BYTE  : frame start marker used unless overridden
//   LEN_W              : width of the frame word-count field
// ---------------------------------------------------------------------------
package loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN0,
      LEN1,
      DATA,
      CSUM,
      DONE,
      ERR
   } state_e;

   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
   localparam int         LEN_W             = 16;

endpackage

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------------------
// byte_packer
// Packs a byte stream little-endian into 32-bit words.
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   clear_i      in   synchronous clear of the byte index and assembly bits
//   byte_valid_i in   byte_i is a data byte to pack this cycle
//   byte_i       in   data byte
//   word_valid_o out  this byte completes a word (combinational)
//   word_o       out  completed word, first byte in [7:0] (combinational)
// ---------------------------------------------------------------------------
module byte_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_valid_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);

   logic [1:0]  byteIdx_q;
   logic [23:0] shift_q;

   // The fourth byte never has to be stored: it goes straight into the top
   // lane of the completed word, so only three bytes are held. Bytes enter at
   // the top and shift down, which leaves the first byte in the low lane.
   assign word_valid_o = byte_valid_i && (byteIdx_q == 2'd3);
   assign word_o       = {byte_i, shift_q};

   // Byte index and assembly register. A clear restarts word alignment so a
   // new frame never inherits a partial word from an aborted one.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byteIdx_q <= 2'd0;
         shift_q   <= 24'd0;
      end else if (clear_i) begin
         byteIdx_q <= 2'd0;
         shift_q   <= 24'd0;
      end else if (byte_valid_i) begin
         byteIdx_q <= byteIdx_q + 2'd1;
         shift_q   <= {byte_i, shift_q[23:8]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
// Boot-time writer for the instruction memory. Receives a framed byte stream
// (sync, len lo, len hi, 4*N data bytes, checksum), writes packed words to
// consecutive word addresses and releases the core only after a good frame.
//   clk         in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   in_valid    in   in_data carries a byte
//   in_data     in   stream byte
//   in_ready    out  loader accepts bytes (1 from first edge after reset)
//   imem_we     out  one-cycle instruction-memory write strobe
//   imem_addr   out  word address of the write
//   imem_wdata  out  instruction word
//   core_hold   out  holds the core in reset while 1
//   done        out  last frame loaded with a good checksum
//   error       out  last frame failed (bad length or checksum)
// ---------------------------------------------------------------------------
module imem_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_W    = 8,
   parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_hold,
   output logic              done,
   output logic              error
);

   localparam logic [LEN_W:0] CAPACITY = (LEN_W+1)'(1) << ADDR_W;

   state_e              state_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    wordCnt_q;
   logic [ADDR_W-1:0]   addrCnt_q;
   logic [7:0]          csum_q;
   logic                inReady_q;
   logic                imemWe_q;
   logic [ADDR_W-1:0]   imemAddr_q;
   logic [31:0]         imemWdata_q;
   logic                coreHold_q;
   logic                done_q;
   logic                error_q;

   logic                accept;
   logic                startFrame;
   logic                wordValid;
   logic [31:0]         wordData;

   // A sync byte only starts a frame outside the frame body; inside DATA the
   // same value is ordinary payload.
   assign accept     = in_valid && inReady_q;
   assign startFrame = accept && (in_data == SYNC_BYTE) &&
                       (state_q == IDLE || state_q == DONE || state_q == ERR);

   byte_packer u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (startFrame),
      .byte_valid_i (accept && (state_q == DATA)),
      .byte_i       (in_data),
      .word_valid_o (wordValid),
      .word_o       (wordData)
   );

   // Frame FSM plus all counters and output registers. Every output is a
   // register so writes and status changes land the cycle after the byte
   // that caused them. The address counter is ADDR_W wide so a full-memory
   // frame wraps it back to 0 after the last write.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         len_q       <= '0;
         wordCnt_q   <= '0;
         addrCnt_q   <= '0;
         csum_q      <= 8'd0;
         inReady_q   <= 1'b0;
         imemWe_q    <= 1'b0;
         imemAddr_q  <= '0;
         imemWdata_q <= 32'd0;
         coreHold_q  <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         inReady_q <= 1'b1;
         imemWe_q  <= wordValid;
         if (wordValid) begin
            imemAddr_q  <= addrCnt_q;
            imemWdata_q <= wordData;
            addrCnt_q   <= addrCnt_q + 1'b1;
         end
         if (accept) begin
            case (state_q)
               IDLE, DONE, ERR: begin
                  if (in_data == SYNC_BYTE) begin
                     state_q    <= LEN0;
                     done_q     <= 1'b0;
                     error_q    <= 1'b0;
                     coreHold_q <= 1'b1;
                     csum_q     <= 8'd0;
                     wordCnt_q  <= '0;
                     addrCnt_q  <= '0;
                  end
               end
               LEN0: begin
                  len_q[7:0] <= in_data;
                  state_q    <= LEN1;
               end
               LEN1: begin
                  len_q[15:8] <= in_data;
                  if ({1'b0, in_data, len_q[7:0]} > CAPACITY) begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end else if ({in_data, len_q[7:0]} == 16'd0) begin
                     state_q <= CSUM;
                  end else begin
                     state_q <= DATA;
                  end
               end
               DATA: begin
                  csum_q <= csum_q + in_data;
                  if (wordValid) begin
                     if (LEN_W'(wordCnt_q + 1'b1) == len_q) begin
                        state_q <= CSUM;
                     end else begin
                        wordCnt_q <= wordCnt_q + 1'b1;
                     end
                  end
               end
               CSUM: begin
                  if (in_data == csum_q) begin
                     state_q    <= DONE;
                     done_q     <= 1'b1;
                     coreHold_q <= 1'b0;
                  end else begin
                     state_q <= ERR;
                     error_q <= 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign in_ready   = inReady_q;
   assign imem_we    = imemWe_q;
   assign imem_addr  = imemAddr_q;
   assign imem_wdata = imemWdata_q;
   assign core_hold  = coreHold_q;
   assign done       = done_q;
   assign error      = error_q;

endmodule
